// File: rtl/rsa_modexp_ctrl.sv
// Modular-exponentiation sequencer: drives one shared Montgomery multiplier through
// pre-transform, left-to-right square-and-multiply and post-transform to return X^E mod N.
module rsa_modexp_ctrl #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [LEN_WIDTH-1:0] e_len,
  input  logic [WIDTH-1:0]     n,
  input  logic [WIDTH-1:0]     r_mod_n,
  input  logic [WIDTH-1:0]     r2_mod_n,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [15:0]          mm_count,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH:0]       mm_result,
  input  logic                 mm_done
);

  localparam int IDX_WIDTH = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [LEN_WIDTH-1:0] EXP_LEN  = LEN_WIDTH'(EXP_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     MONT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]          COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_SQUARE = 3'd2,
    S_MULT   = 3'd3,
    S_POST   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state_r;
  logic [EXP_WIDTH-1:0] e_r;
  logic [LEN_WIDTH-1:0] i_r;
  logic                 len_zero_r;
  logic [WIDTH-1:0]     acc_r;
  logic [WIDTH-1:0]     xt_r;

  logic [LEN_WIDTH-1:0] eff_len_s;
  logic                 e_bit_s;
  logic [WIDTH-1:0]     prod_s;
  logic                 unused_s;

  // Clamp the requested exponent length to the exponent register width.
  always_comb begin
    eff_len_s = e_len;
    if (e_len > EXP_LEN) begin
      eff_len_s = EXP_LEN;
    end else begin
      eff_len_s = e_len;
    end
  end

  // The multiplier guarantees its output is already reduced below N, so the top bit is dropped.
  assign prod_s   = mm_result[WIDTH-1:0];
  assign unused_s = mm_result[WIDTH];
  assign e_bit_s  = e_r[i_r[IDX_WIDTH-1:0]];

  // Sequencer FSM; every multiplier operand and handshake output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      e_r        <= {EXP_WIDTH{1'b0}};
      i_r        <= LEN_ZERO;
      len_zero_r <= 1'b0;
      acc_r      <= {WIDTH{1'b0}};
      xt_r       <= {WIDTH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= {WIDTH{1'b0}};
      mm_count   <= 16'd0;
      mm_start   <= 1'b0;
      mm_a       <= {WIDTH{1'b0}};
      mm_b       <= {WIDTH{1'b0}};
      mm_m       <= {WIDTH{1'b0}};
    end else begin
      mm_start <= 1'b0;
      if (mm_start && (mm_count != COUNT_MAX)) begin
        mm_count <= mm_count + 16'd1;
      end
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r    <= S_PRE;
            busy       <= 1'b1;
            mm_count   <= 16'd0;
            e_r        <= e;
            i_r        <= eff_len_s - LEN_ONE;
            len_zero_r <= (eff_len_s == LEN_ZERO);
            acc_r      <= r_mod_n;
            mm_m       <= n;
            mm_a       <= x;
            mm_b       <= r2_mod_n;
            mm_start   <= 1'b1;
          end
        end
        S_PRE: begin
          if (mm_done) begin
            xt_r     <= prod_s;
            mm_a     <= acc_r;
            mm_start <= 1'b1;
            if (len_zero_r) begin
              state_r <= S_POST;
              mm_b    <= MONT_ONE;
            end else begin
              state_r <= S_SQUARE;
              mm_b    <= acc_r;
            end
          end
        end
        S_SQUARE: begin
          if (mm_done) begin
            acc_r    <= prod_s;
            mm_a     <= prod_s;
            mm_start <= 1'b1;
            if (e_bit_s) begin
              state_r <= S_MULT;
              mm_b    <= xt_r;
            end else if (i_r == LEN_ZERO) begin
              state_r <= S_POST;
              mm_b    <= MONT_ONE;
            end else begin
              i_r  <= i_r - LEN_ONE;
              mm_b <= prod_s;
            end
          end
        end
        S_MULT: begin
          if (mm_done) begin
            acc_r    <= prod_s;
            mm_a     <= prod_s;
            mm_start <= 1'b1;
            if (i_r == LEN_ZERO) begin
              state_r <= S_POST;
              mm_b    <= MONT_ONE;
            end else begin
              state_r <= S_SQUARE;
              i_r     <= i_r - LEN_ONE;
              mm_b    <= prod_s;
            end
          end
        end
        S_POST: begin
          // Multiplying by 1 leaves the Montgomery domain.
          if (mm_done) begin
            result  <= prod_s;
            state_r <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl with a behavioural 8-bit Montgomery multiplier (L=3)
// and a scoreboard of expected results checked against a plain modular-power reference.
module tb_rsa_modexp_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x = 8'h00, e = 8'h00, n = 8'h00, r_mod_n = 8'h00, r2_mod_n = 8'h00;
  logic [10:0] e_len = 11'd0;
  logic        busy, done, mm_start, mm_done;
  logic [7:0]  result, mm_a, mm_b, mm_m;
  logic [15:0] mm_count;
  logic [8:0]  mm_result;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int         cnt_q[$];
  int start_seen = 0;
  int done_seen = 0;
  int stab_err = 0;
  logic spur_req = 1'b0;
  int pend;
  logic [7:0] hold_a, hold_b, pres;

  rsa_modexp_ctrl #(.WIDTH(8), .EXP_WIDTH(8), .LEN_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .e(e), .e_len(e_len), .n(n),
    .r_mod_n(r_mod_n), .r2_mod_n(r2_mod_n), .busy(busy), .done(done), .result(result),
    .mm_count(mm_count), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    logic [16:0] t;
    t = 17'(a) * 17'(b);
    for (int k = 0; k < 8; k++) begin
      if (t[0]) t = t + 17'(m);
      t = t >> 1;
    end
    if (t >= 17'(m)) t = t - 17'(m);
    return t[7:0];
  endfunction

  function automatic logic [7:0] modpow(input logic [7:0] xb, input logic [7:0] eb, input int len,
                                        input logic [7:0] m);
    int r;
    r = 1 % int'(m);
    for (int k = len - 1; k >= 0; k--) begin
      r = (r * r) % int'(m);
      if (eb[3'(k)]) r = (r * int'(xb)) % int'(m);
    end
    return 8'(r);
  endfunction

  // Montgomery multiplier model: answers each mm_start 3 cycles later, checks operand stability.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_done   <= 1'b0;
      mm_result <= 9'h000;
      pend      <= 0;
    end else begin
      mm_done <= 1'b0;
      if (spur_req) begin
        mm_done   <= 1'b1;
        mm_result <= 9'h0AA;
      end
      if (mm_start) begin
        pend   <= 2;
        hold_a <= mm_a;
        hold_b <= mm_b;
        pres   <= mont(mm_a, mm_b, mm_m);
      end else if (pend != 0) begin
        if (mm_a !== hold_a || mm_b !== hold_b) stab_err <= stab_err + 1;
        if (pend == 1) begin
          mm_done   <= 1'b1;
          mm_result <= {1'b0, pres};
        end
        pend <= pend - 1;
      end
    end
  end

  // Pulse counters for start and done events.
  always @(posedge clk) begin
    if (mm_start) start_seen <= start_seen + 1;
    if (done) done_seen <= done_seen + 1;
  end

  task automatic apply(input logic [7:0] xv, input logic [7:0] ev, input logic [10:0] lv,
                       input logic [7:0] nv, input bit push);
    int len, pc;
    logic [7:0] rm;
    len = (lv > 11'd8) ? 8 : int'(lv);
    pc = 0;
    for (int k = 0; k < len; k++) pc += int'(ev[3'(k)]);
    rm = 8'(256 % int'(nv));
    x = xv; e = ev; e_len = lv; n = nv; r_mod_n = rm;
    r2_mod_n = 8'((int'(rm) * int'(rm)) % int'(nv));
    if (push) begin
      exp_q.push_back(modpow(xv, ev, len, nv));
      cnt_q.push_back(2 + len + pc);
    end
  endtask

  task automatic wait_done(input string name, output int cyc);
    logic [7:0] er;
    int ec;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    er = exp_q.pop_front();
    ec = cnt_q.pop_front();
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
    end else begin
      total++;
      if (result !== er) begin
        bad++;
        $display("FAIL %s result: got %h expected %h", name, result, er);
      end
      total++;
      if (mm_count !== 16'(ec)) begin
        bad++;
        $display("FAIL %s mm_count: got %0d expected %0d", name, mm_count, ec);
      end
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] xv, input logic [7:0] ev,
                        input logic [10:0] lv, input logic [7:0] nv,
                        output int lat, output logic b1, output logic s1);
    @(negedge clk);
    apply(xv, ev, lv, nv, 1'b1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    b1 = busy;
    s1 = mm_start;
    wait_done(name, lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, mm_start, result, mm_count, mm_a, mm_b, mm_m} !== 59'd0) begin
      bad++;
      $display("FAIL reset_state: got %h expected 0", {busy, done, mm_start, result, mm_count, mm_a, mm_b, mm_m});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic b1, s1;
    run_op("basic", 8'h05, 8'h03, 11'd2, 8'hC5, lat, b1, s1);
    total++;
    if (result !== 8'h7D || mm_count !== 16'd6) begin
      bad++;
      $display("FAIL basic_const: got %h/%0d expected 7d/6", result, mm_count);
    end
    total++;
    if (lat !== 25) begin
      bad++;
      $display("FAIL basic_latency: got %0d expected 25", lat);
    end
    total++;
    if (b1 !== 1'b1 || s1 !== 1'b1) begin
      bad++;
      $display("FAIL basic_first_cycle: busy=%b mm_start=%b expected 1/1", b1, s1);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse: done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_zero_len();
    int lat;
    logic b1, s1;
    run_op("zero_len", 8'h05, 8'h03, 11'd0, 8'hC5, lat, b1, s1);
    total++;
    if (result !== 8'h01 || mm_count !== 16'd2) begin
      bad++;
      $display("FAIL zero_len_const: got %h/%0d expected 01/2", result, mm_count);
    end
  endtask

  task automatic test_leading_zeros();
    int lat;
    logic b1, s1;
    run_op("lead8", 8'h05, 8'h03, 11'd8, 8'hC5, lat, b1, s1);
    total++;
    if (result !== 8'h7D || mm_count !== 16'd12) begin
      bad++;
      $display("FAIL lead8_const: got %h/%0d expected 7d/12", result, mm_count);
    end
    run_op("clamp200", 8'h05, 8'h03, 11'd200, 8'hC5, lat, b1, s1);
    total++;
    if (result !== 8'h7D || mm_count !== 16'd12) begin
      bad++;
      $display("FAIL clamp200_const: got %h/%0d expected 7d/12", result, mm_count);
    end
  endtask

  task automatic test_busy_reject();
    int lat, d0;
    @(negedge clk);
    d0 = done_seen;
    apply(8'h05, 8'h03, 11'd2, 8'hC5, 1'b1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    apply(8'h07, 8'hFF, 11'd8, 8'hC5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_reject", lat);
    total++;
    if (result !== 8'h7D) begin
      bad++;
      $display("FAIL busy_reject_result: got %h expected 7d", result);
    end
    repeat (40) @(negedge clk);
    total++;
    if (done_seen - d0 !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_reject_once: dones=%0d busy=%b expected 1/0", done_seen - d0, busy);
    end
  endtask

  task automatic test_spurious_done();
    int s0, d0;
    @(negedge clk);
    s0 = start_seen;
    d0 = done_seen;
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (result !== 8'h7D || busy !== 1'b0 || start_seen !== s0 || done_seen !== d0) begin
      bad++;
      $display("FAIL spurious_done: result=%h busy=%b starts=%0d dones=%0d expected 7d/0/0/0",
               result, busy, start_seen - s0, done_seen - d0);
    end
  endtask

  task automatic test_reset_midrun();
    int s0, d0, guard, lat;
    logic b1, s1;
    @(negedge clk);
    s0 = start_seen;
    apply(8'h05, 8'h03, 11'd2, 8'hC5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (start_seen < s0 + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (start_seen < s0 + 2) begin
      bad++;
      $display("FAIL reset_mid_reach: starts=%0d expected 2", start_seen - s0);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, mm_start, result, mm_count, mm_a, mm_b, mm_m} !== 59'd0) begin
      bad++;
      $display("FAIL reset_mid_clear: got %h expected 0", {busy, done, mm_start, result, mm_count, mm_a, mm_b, mm_m});
    end
    @(negedge clk);
    reset = 1'b0;
    s0 = start_seen;
    d0 = done_seen;
    repeat (20) @(negedge clk);
    total++;
    if (start_seen !== s0 || done_seen !== d0) begin
      bad++;
      $display("FAIL reset_mid_quiet: starts=%0d dones=%0d expected 0/0", start_seen - s0, done_seen - d0);
    end
    run_op("reset_rerun", 8'h05, 8'h03, 11'd2, 8'hC5, lat, b1, s1);
    total++;
    if (result !== 8'h7D) begin
      bad++;
      $display("FAIL reset_rerun_const: got %h expected 7d", result);
    end
  endtask

  task automatic test_random();
    int lat;
    logic b1, s1;
    logic [7:0] nv, xv, ev;
    logic [10:0] lv;
    for (int t = 0; t < 200; t++) begin
      nv = 8'($urandom_range(1, 127) * 2 + 1);
      xv = 8'($urandom_range(0, int'(nv) - 1));
      ev = 8'($urandom);
      lv = 11'($urandom_range(0, 12));
      run_op("random", xv, ev, lv, nv, lat, b1, s1);
    end
  endtask

  task automatic test_stability();
    total++;
    if (stab_err !== 0) begin
      bad++;
      $display("FAIL operand_stability: changes=%0d expected 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_leading_zeros();
    test_busy_reject();
    test_spurious_done();
    test_reset_midrun();
    test_random();
    test_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
# rsa_modexp_ctrl

- Parametrised on-chip modular-exponentiation sequencer that computes X^E mod N with no CPU intervention.
- Replaces the per-multiplication CPU command loop: it repeatedly drives the existing `montgomery` multiplier through pre-transform, left-to-right square-and-multiply over a programmable exponent length, and post-transform.
- Sits between the DMA-loaded operand registers of the RSA top level and one shared Montgomery multiplier instance.
- Returns the reduced result with a start/busy/done handshake.

## Interface

Parameters:
- `WIDTH`, 1024: operand and modulus width in bits; Montgomery radix R = 2^WIDTH.
- `EXP_WIDTH`, 1024: exponent register width.
- `LEN_WIDTH`, 11: width of `e_len`; must satisfy 2^LEN_WIDTH > EXP_WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `x`  in  WIDTH  base, must be < N.
- `e`  in  EXP_WIDTH  exponent.
- `e_len`  in  LEN_WIDTH  number of exponent bits to process, starting at bit `e_len`-1.
- `n`  in  WIDTH  odd modulus.
- `r_mod_n`  in  WIDTH  R mod N.
- `r2_mod_n`  in  WIDTH  R² mod N.
- `busy`  out  1  high from the cycle after an accepted start until DONE.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  WIDTH  X^E mod N; held until the next accepted start.
- `mm_count`  out  16  number of multiplications issued in the current or last run.
- `mm_start`  out  1  one-cycle start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m`  out  WIDTH each  multiplier operands; `mm_m` is the latched N.
- `mm_result`  in  WIDTH+1  multiplier output; the low WIDTH bits are used, and the multiplier guarantees the value is < N.
- `mm_done`  in  1  one-cycle pulse; `mm_result` is valid in the same cycle.

## Operation

- **Start acceptance:** on an accepted `start`, all inputs are latched (x, e, n, r_mod_n, r2_mod_n, e_len), `mm_count` clears, and the bit index i is set to min(`e_len`, EXP_WIDTH) − 1.
- **Input stability:** inputs may change freely after the start cycle.
- **States:** IDLE, PRE, SQUARE, MULT, POST, DONE.
- **PRE:** issue MM(x, r2_mod_n) and store the result in X̃. Accumulator A ← r_mod_n. Go to SQUARE if the effective length > 0, else POST.
- **SQUARE:** issue MM(A, A) and capture it into A. Then:
  - if e[i] = 1, go to MULT;
  - else if i = 0, go to POST;
  - else decrement i and stay in SQUARE (re-issue).
- **MULT:** issue MM(A, X̃) and capture it into A. Then go to POST if i = 0, else decrement i and go to SQUARE.
- **POST:** issue MM(A, 1) and capture it into `result`. Go to DONE.
- **DONE:** pulse `done` for one cycle and return to IDLE.
- **Issue rule:** in each MM state, `mm_start` is high only in the first cycle of that state. The state waits for `mm_done`, and the capture and transition happen on the edge where `mm_done` = 1.
- **`mm_count`:** increments on every `mm_start`; saturates at 0xFFFF.
- **`e_len` boundaries:**
  - `e_len` = 0 → result = 1 mod N (for N > 1), using 2 multiplications.
  - `e_len` > EXP_WIDTH → clamped to EXP_WIDTH.
- **Leading zero bits** inside `e_len` are processed as normal squarings; correctness is unaffected.
- **Busy and spurious inputs:**
  - `start` while not IDLE is ignored and does not queue.
  - A spurious `mm_done` in IDLE or DONE is ignored.

## Timing

Reset values, applied asynchronously while `reset` = 1:
- state IDLE;
- `busy`, `done`, `mm_start` = 0;
- `result`, A, X̃ and `mm_count` = 0;
- `mm_a`, `mm_b`, `mm_m` = 0.

Latency and handshake:
- `start` seen at edge k → PRE entered, `busy` = 1 and `mm_start` = 1 in cycle k+1.
- If the multiplier asserts `mm_done` L cycles after `mm_start`, each multiplication occupies L+1 cycles including its issue cycle.
- The next `mm_start` follows in the cycle after a capture.
- Total start-to-`done` latency = M·(L+1) + 1 cycles, where M = 2 + effective length + popcount(e over the processed bits).
- `done` and `busy` = 0 occur together in the DONE cycle. `start` is accepted again from the following cycle.
- `mm_a` and `mm_b` are registered, stable from the `mm_start` cycle until `mm_done`.
- **Reset mid-run:** reset during any state aborts the run immediately. No `done` is produced, and no `mm_start` is issued after reset deasserts until a new `start`.

## Test plan

The bench uses a behavioural Montgomery model with WIDTH=8, EXP_WIDTH=8, L=3.

- **Basic exponentiation:**
  - Stimulus: N=0xC5, r_mod_n=0x3B, r2_mod_n=0x84, x=0x05, e=0x03, e_len=2.
  - Required: result=0x7D, mm_count=6, `done` exactly 25 cycles after the start cycle.
- **Zero length:** same operands with e_len=0 → result=0x01, mm_count=2.
- **Leading zeros and clamping:**
  - e=0x03, e_len=8 → result=0x7D, mm_count=12.
  - e_len=200 gives the identical result and mm_count.
- **Busy rejection:** pulse `start` with different operands while `busy` → ignored; the first run's result is 0x7D and `done` pulses exactly once.
- **Reset mid-run:** assert `reset` during SQUARE → all outputs 0 immediately; no `done` and no `mm_start` until a new `start`; a rerun then gives 0x7D.
- **Randomised check:** 200 random runs (odd N > 1, x < N, random e, e_len) against a reference modular-power model → all results match, and mm_count matches 2 + len + popcount.
